// File: rtl/riscv_input_pkg.sv
// Shared definitions for the front-panel input stage: entry FSM states,
// digit width, button indices (index order is the action priority) and
// digit wrap helpers.
// Build option: OPERAND_BCD_EN selects decimal digits (0-9) instead of hex.
package riscv_input_pkg;

    typedef enum logic [1:0] {
        EDIT  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } entry_state_t;

    localparam int unsigned DIGIT_W = 4;

    // Lower index wins when several presses arrive in the same cycle.
    localparam int unsigned BTN_CENTER = 0;
    localparam int unsigned BTN_UP     = 1;
    localparam int unsigned BTN_DOWN   = 2;
    localparam int unsigned BTN_LEFT   = 3;
    localparam int unsigned BTN_RIGHT  = 4;
    localparam int unsigned NUM_BTNS   = 5;

`ifdef OPERAND_BCD_EN
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
`else
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'hF;
`endif

    function automatic logic [DIGIT_W-1:0] digit_inc(input logic [DIGIT_W-1:0] d);
        return (d >= DIGIT_MAX) ? '0 : d + 1'b1;
    endfunction

    function automatic logic [DIGIT_W-1:0] digit_dec(input logic [DIGIT_W-1:0] d);
        return (d == '0) ? DIGIT_MAX : d - 1'b1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: 2-flop synchronizer, consecutive-cycle
// debouncer with a stable level, and a registered one-cycle press pulse on
// each accepted 0->1 transition of the stable level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync0;
    logic             sync1;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    // Synchronize, count disagreeing cycles, flip the stable level, pulse on rise.
    // The counter restarts on every flip, so it never exceeds CNT_LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0    <= 1'b0;
            sync1    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync0    <= btn_raw;
            sync1    <= sync0;
            stable_d <= stable;
            press    <= stable & ~stable_d;
            if (sync1 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_operand_entry.sv
// Front-panel operand entry: five debounced buttons edit a multi-digit
// operand under a cursor and launch a calculation on the core, holding off
// edits until the core signals completion.
// Build option: OPERAND_BCD_EN selects decimal digits (0-9) instead of hex.
module btn_operand_entry
    import riscv_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned DIGITS          = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        btn_center_in,
    input  logic                        btn_up_in,
    input  logic                        btn_left_in,
    input  logic                        btn_down_in,
    input  logic                        btn_right_in,
    input  logic                        calc_done,
    output logic [DIGIT_W*DIGITS-1:0]   operand,
    output logic [$clog2(DIGITS)-1:0]   cursor,
    output logic                        calc_start,
    output logic                        busy
);

    localparam int unsigned CUR_W = $clog2(DIGITS);
    localparam logic [CUR_W-1:0] CUR_LAST = CUR_W'(DIGITS - 1);

    logic [NUM_BTNS-1:0]       btn_raw;
    logic [NUM_BTNS-1:0]       press;
    entry_state_t              state;
    entry_state_t              state_next;
    logic [DIGIT_W*DIGITS-1:0] operand_next;
    logic [CUR_W-1:0]          cursor_next;
    logic [DIGIT_W-1:0]        digit_sel;

    assign btn_raw[BTN_CENTER] = btn_center_in;
    assign btn_raw[BTN_UP]     = btn_up_in;
    assign btn_raw[BTN_DOWN]   = btn_down_in;
    assign btn_raw[BTN_LEFT]   = btn_left_in;
    assign btn_raw[BTN_RIGHT]  = btn_right_in;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(btn_raw[i]),
            .press  (press[i])
        );
    end

    // State, operand and cursor registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EDIT;
            operand <= '0;
            cursor  <= '0;
        end else begin
            state   <= state_next;
            operand <= operand_next;
            cursor  <= cursor_next;
        end
    end

    // Next-state, prioritised edit action and status outputs.
    always_comb begin
        state_next   = state;
        operand_next = operand;
        cursor_next  = cursor;
        digit_sel    = operand[cursor*DIGIT_W +: DIGIT_W];
        case (state)
            EDIT: begin
                if (press[BTN_CENTER]) begin
                    state_next = START;
                end else if (press[BTN_UP]) begin
                    operand_next[cursor*DIGIT_W +: DIGIT_W] = digit_inc(digit_sel);
                end else if (press[BTN_DOWN]) begin
                    operand_next[cursor*DIGIT_W +: DIGIT_W] = digit_dec(digit_sel);
                end else if (press[BTN_LEFT]) begin
                    cursor_next = (cursor == CUR_LAST) ? '0 : cursor + 1'b1;
                end else if (press[BTN_RIGHT]) begin
                    cursor_next = (cursor == '0) ? CUR_LAST : cursor - 1'b1;
                end
            end
            START:   state_next = WAIT;
            WAIT:    if (calc_done) state_next = EDIT;
            default: state_next = EDIT;
        endcase
        calc_start = (state == START);
        busy       = (state != EDIT);
    end

endmodule

// File: tb/tb_btn_operand_entry.sv
// Self-checking bench for btn_operand_entry (hex build, 4 digits, 4-cycle debounce).
module tb_btn_operand_entry;

    localparam int unsigned N   = 4;
    localparam int unsigned LAT = N + 4;  // posedges from drive (at negedge) to visible update

    localparam logic [4:0] C = 5'b00001;
    localparam logic [4:0] U = 5'b00010;
    localparam logic [4:0] D = 5'b00100;
    localparam logic [4:0] L = 5'b01000;
    localparam logic [4:0] R = 5'b10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        bc, bu, bl, bd, br;
    logic        calc_done;
    logic [15:0] operand;
    logic [1:0]  cursor;
    logic        calc_start;
    logic        busy;

    always #5 clk = ~clk;

    btn_operand_entry #(
        .DEBOUNCE_CYCLES(N),
        .DIGITS         (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_center_in(bc),
        .btn_up_in    (bu),
        .btn_left_in  (bl),
        .btn_down_in  (bd),
        .btn_right_in (br),
        .calc_done    (calc_done),
        .operand      (operand),
        .cursor       (cursor),
        .calc_start   (calc_start),
        .busy         (busy)
    );

    typedef struct {
        logic [4:0]  mask;
        logic [15:0] op;
        logic [1:0]  cur;
    } vec_t;

    typedef struct {
        logic [15:0] op;
        logic [1:0]  cur;
    } exp_t;

    vec_t tbl[18];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   starts = 0;

    always @(negedge clk) if (calc_start) starts++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_btns(input logic [4:0] m);
        {br, bl, bd, bu, bc} = m;
    endtask

    // Press, verify nothing moved one edge early, verify the update, release.
    task automatic press_and_check(input string name, input logic [4:0] m,
                                   input logic [15:0] op, input logic [1:0] cur,
                                   input logic [15:0] prev_op, input logic [1:0] prev_cur);
        exp_t e;
        @(negedge clk);
        set_btns(m);
        sb.push_back('{op, cur});
        repeat (LAT - 1) @(posedge clk);
        #1;
        check({name, " early op"}, operand, prev_op);
        check({name, " early cur"}, cursor, prev_cur);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({name, " op"}, operand, e.op);
        check({name, " cur"}, cursor, e.cur);
        repeat (2) @(negedge clk);
        set_btns(5'b0);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        logic [15:0] prev_op;
        logic [1:0]  prev_cur;
        int          s0;
        logic        bounce [6];

        tbl[0]  = '{U,     16'h0001, 2'd0};
        tbl[1]  = '{U,     16'h0002, 2'd0};
        tbl[2]  = '{U,     16'h0003, 2'd0};
        tbl[3]  = '{U,     16'h0004, 2'd0};
        tbl[4]  = '{U,     16'h0005, 2'd0};
        tbl[5]  = '{L,     16'h0005, 2'd1};
        tbl[6]  = '{L,     16'h0005, 2'd2};
        tbl[7]  = '{L,     16'h0005, 2'd3};
        tbl[8]  = '{U,     16'h1005, 2'd3};
        tbl[9]  = '{U | L, 16'h2005, 2'd3};
        tbl[10] = '{L,     16'h2005, 2'd0};
        tbl[11] = '{R,     16'h2005, 2'd3};
        tbl[12] = '{D,     16'h1005, 2'd3};
        tbl[13] = '{D,     16'h0005, 2'd3};
        tbl[14] = '{D,     16'hF005, 2'd3};
        tbl[15] = '{D | R, 16'hE005, 2'd3};
        tbl[16] = '{R,     16'hE005, 2'd2};
        tbl[17] = '{U | D | L | R, 16'hE105, 2'd2};

        bounce[0] = 1'b1; bounce[1] = 1'b0; bounce[2] = 1'b1;
        bounce[3] = 1'b1; bounce[4] = 1'b1; bounce[5] = 1'b1;

        rst = 1'b1;
        calc_done = 1'b0;
        set_btns(5'b0);
        repeat (5) @(posedge clk);
        #1;
        check("reset operand", operand, 16'h0000);
        check("reset cursor", cursor, 2'd0);
        check("reset calc_start", calc_start, 1'b0);
        check("reset busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        prev_op  = 16'h0000;
        prev_cur = 2'd0;
        for (int i = 0; i < 18; i++) begin
            press_and_check($sformatf("vec%0d", i), tbl[i].mask, tbl[i].op, tbl[i].cur,
                            prev_op, prev_cur);
            prev_op  = tbl[i].op;
            prev_cur = tbl[i].cur;
        end

        // 3-cycle glitch must be rejected
        @(negedge clk);
        set_btns(U);
        repeat (3) @(negedge clk);
        set_btns(5'b0);
        repeat (15) @(negedge clk);
        check("glitch op", operand, 16'hE105);

        // bouncing rise gives exactly one increment
        for (int i = 0; i < 6; i++) begin
            bu = bounce[i];
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        bu = 1'b0;
        repeat (12) @(negedge clk);
        check("bounce op", operand, 16'hE205);
        check("bounce cur", cursor, 2'd2);

        // center: one-cycle start, calc_done during START ignored
        s0 = starts;
        @(negedge clk);
        set_btns(C);
        repeat (LAT) @(posedge clk);
        #1;
        check("start pulse", calc_start, 1'b1);
        check("start busy", busy, 1'b1);
        calc_done = 1'b1;
        @(posedge clk);
        #1;
        calc_done = 1'b0;
        check("start ends", calc_start, 1'b0);
        check("done in START ignored", busy, 1'b1);
        @(negedge clk);
        set_btns(5'b0);
        repeat (5) @(negedge clk);
        set_btns(U);
        repeat (10) @(negedge clk);
        set_btns(5'b0);
        repeat (10) @(negedge clk);
        check("wait frozen op", operand, 16'hE205);
        check("wait busy", busy, 1'b1);
        check("start count", starts - s0, 1);
        calc_done = 1'b1;
        @(posedge clk);
        #1;
        calc_done = 1'b0;
        check("done clears busy", busy, 1'b0);
        press_and_check("up after done", U, 16'hE305, 2'd2, 16'hE205, 2'd2);

        // reset during WAIT
        @(negedge clk);
        set_btns(C);
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("wait before rst", busy, 1'b1);
        @(negedge clk);
        set_btns(5'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst op", operand, 16'h0000);
        check("rst cur", cursor, 2'd0);
        check("rst busy", busy, 1'b0);
        check("rst calc_start", calc_start, 1'b0);

        // up held through reset -> exactly one press after release
        @(negedge clk);
        set_btns(U);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sb.push_back('{16'h0001, 2'd0});
        repeat (LAT - 1) @(posedge clk);
        #1;
        check("held early op", operand, 16'h0000);
        @(posedge clk);
        #1;
        begin
            exp_t e;
            e = sb.pop_front();
            check("held op", operand, e.op);
        end
        repeat (10) @(negedge clk);
        set_btns(5'b0);
        repeat (12) @(negedge clk);
        check("held single", operand, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
